// File: rtl/alu_pkg.sv
// Shared definitions for the Mini SRC ALU: data widths and opcode encodings.
package alu_pkg;

  localparam int DATA_W   = 32;
  localparam int RESULT_W = 64;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu_div.sv
// Combinational 32-step signed non-restoring divider.
// Divides magnitudes, then restores signs: quotient truncates toward zero,
// remainder takes the sign of the dividend. Divide-by-zero returns an
// all-ones quotient and the dividend as remainder; 0x8000_0000 / -1
// returns 0x8000_0000 with a zero remainder.
import alu_pkg::*;

module alu_div (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] quo_o,
  output logic [DATA_W-1:0] rem_o
);

  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] q_mag;
  logic [DATA_W-1:0] r_mag;
  logic signed [DATA_W+1:0] r_acc;
  logic [1:0] unused_r_top;

  // Operand magnitudes; 0x8000_0000 maps to 2^31, which is the correct unsigned magnitude.
  always_comb begin
    a_mag = a_i[DATA_W-1] ? (32'd0 - a_i) : a_i;
    b_mag = b_i[DATA_W-1] ? (32'd0 - b_i) : b_i;
  end

  // Non-restoring iteration on magnitudes, with a final remainder correction.
  always_comb begin
    logic signed [DATA_W+1:0] d_ext;
    logic signed [DATA_W+1:0] r_sh;
    d_ext = $signed({2'b00, b_mag});
    r_acc = '0;
    q_mag = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      r_sh = $signed({r_acc[DATA_W:0], a_mag[i]});
      if (!r_acc[DATA_W+1]) begin
        r_acc = r_sh - d_ext;
      end else begin
        r_acc = r_sh + d_ext;
      end
      q_mag[i] = ~r_acc[DATA_W+1];
    end
    if (r_acc[DATA_W+1]) begin
      r_acc = r_acc + d_ext;
    end
    r_mag = r_acc[DATA_W-1:0];
  end

  // The corrected remainder is below the divisor, so the top bits are always zero.
  assign unused_r_top = r_acc[DATA_W+1:DATA_W];

  // Sign restoration and the two special cases.
  always_comb begin
    quo_o = (a_i[DATA_W-1] ^ b_i[DATA_W-1]) ? (32'd0 - q_mag) : q_mag;
    rem_o = a_i[DATA_W-1] ? (32'd0 - r_mag) : r_mag;
    if (b_i == '0) begin
      quo_o = 32'hFFFF_FFFF;
      rem_o = a_i;
    end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
      quo_o = 32'h8000_0000;
      rem_o = '0;
    end
  end

endmodule

// File: rtl/alu.sv
// Mini SRC 32-bit integer ALU. Operand A is Y_in, operand B is B_in.
// C_result is combinational; Z_hi/Z_lo register it every clock.
// Build option: define ALU_DIV_EN to include the divider; without it
// the div opcode produces zero like any unlisted opcode.
import alu_pkg::*;

module alu (
  input  logic                clk,
  input  logic                clear,
  input  logic [4:0]          instruction,
  input  logic [DATA_W-1:0]   B_in,
  input  logic [DATA_W-1:0]   Y_in,
  output logic [RESULT_W-1:0] C_result,
  output logic [DATA_W-1:0]   Z_hi,
  output logic [DATA_W-1:0]   Z_lo
);

  logic [DATA_W-1:0]   c_hi;
  logic [DATA_W-1:0]   c_lo;
  logic [4:0]          sh_amt;
  logic [RESULT_W-1:0] prod;
  logic [DATA_W-1:0]   z_hi_q, z_hi_d;
  logic [DATA_W-1:0]   z_lo_q, z_lo_d;

  function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] a,
                                              input logic [4:0] sh);
    // Shifting a 32-bit value by 32 yields zero, so a count of 0 returns a.
    return (a >> sh) | (a << (6'd32 - {1'b0, sh}));
  endfunction

  function automatic logic [DATA_W-1:0] rol32(input logic [DATA_W-1:0] a,
                                              input logic [4:0] sh);
    return (a << sh) | (a >> (6'd32 - {1'b0, sh}));
  endfunction

  assign sh_amt = B_in[4:0];

  // Full signed product: sign-extend both operands, the low 64 bits are exact.
  assign prod = {{DATA_W{Y_in[DATA_W-1]}}, Y_in} * {{DATA_W{B_in[DATA_W-1]}}, B_in};

`ifdef ALU_DIV_EN
  logic [DATA_W-1:0] div_quo;
  logic [DATA_W-1:0] div_rem;

  alu_div u_div (
    .a_i   (Y_in),
    .b_i   (B_in),
    .quo_o (div_quo),
    .rem_o (div_rem)
  );
`endif

  // Opcode decode into the 64-bit combinational result.
  always_comb begin
    c_hi = '0;
    c_lo = '0;
    case (instruction)
      OP_ADD:  c_lo = Y_in + B_in;
      OP_SUB:  c_lo = Y_in - B_in;
      OP_AND:  c_lo = Y_in & B_in;
      OP_OR:   c_lo = Y_in | B_in;
      OP_SHR:  c_lo = Y_in >> sh_amt;
      OP_SHRA: c_lo = $unsigned($signed(Y_in) >>> sh_amt);
      OP_SHL:  c_lo = Y_in << sh_amt;
      OP_ROR:  c_lo = ror32(Y_in, sh_amt);
      OP_ROL:  c_lo = rol32(Y_in, sh_amt);
      OP_MUL: begin
        c_hi = prod[RESULT_W-1:DATA_W];
        c_lo = prod[DATA_W-1:0];
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        c_hi = div_rem;
        c_lo = div_quo;
      end
`endif
      OP_NEG:  c_lo = 32'd0 - B_in;
      OP_NOT:  c_lo = ~B_in;
      default: begin
        c_hi = '0;
        c_lo = '0;
      end
    endcase
  end

  assign C_result = {c_hi, c_lo};

  // Z register next state: clear wins over the load.
  always_comb begin
    z_hi_d = c_hi;
    z_lo_d = c_lo;
    if (clear) begin
      z_hi_d = '0;
      z_lo_d = '0;
    end
  end

  // Z register pair.
  always_ff @(posedge clk) begin
    z_hi_q <= z_hi_d;
    z_lo_q <= z_lo_d;
  end

  assign Z_hi = z_hi_q;
  assign Z_lo = z_lo_q;

endmodule

// File: tb/tb_alu.sv
// Directed testbench for alu: combinational result per opcode, Z register
// latency and the synchronous clear.
`timescale 1ns/1ps
module tb_alu;

  logic        clk;
  logic        clear;
  logic [4:0]  instruction;
  logic [31:0] B_in;
  logic [31:0] Y_in;
  logic [63:0] C_result;
  logic [31:0] Z_hi;
  logic [31:0] Z_lo;

  int n_checks = 0;
  int n_errors = 0;

  alu dut (
    .clk         (clk),
    .clear       (clear),
    .instruction (instruction),
    .B_in        (B_in),
    .Y_in        (Y_in),
    .C_result    (C_result),
    .Z_hi        (Z_hi),
    .Z_lo        (Z_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands at the falling edge, then check the combinational result.
  task automatic op(input string tag, input logic [4:0] opc, input logic [31:0] y,
                    input logic [31:0] b, input logic [63:0] exp);
    @(negedge clk);
    instruction = opc;
    Y_in        = y;
    B_in        = b;
    #1;
    check_eq(tag, C_result, exp);
  endtask

  task automatic check_z(input string tag, input logic [63:0] exp);
    @(posedge clk);
    #1;
    check_eq(tag, {Z_hi, Z_lo}, exp);
  endtask

  initial begin
    clear       = 1'b1;
    instruction = 5'b00000;
    Y_in        = '0;
    B_in        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_z", {Z_hi, Z_lo}, 64'h0);

    @(negedge clk);
    clear = 1'b0;

    // Y=240, B=3 logic/arith
    op("add",  5'b00011, 32'd240, 32'd3, 64'd243);
    op("sub",  5'b00100, 32'd240, 32'd3, 64'd237);
    op("and",  5'b00101, 32'd240, 32'd3, 64'd0);
    op("or",   5'b00110, 32'd240, 32'd3, 64'd243);
    op("not",  5'b10010, 32'd240, 32'd3, 64'h0000_0000_FFFF_FFFC);
    op("neg",  5'b10001, 32'd240, 32'd3, 64'h0000_0000_FFFF_FFFD);
    op("add_wrap", 5'b00011, 32'hFFFF_FFFF, 32'd2, 64'd1);

    // Y=240, B=3 shifts
    op("shr",  5'b00111, 32'd240, 32'd3, 64'd30);
    op("shra", 5'b01000, 32'd240, 32'd3, 64'd30);
    op("shl",  5'b01001, 32'd240, 32'd3, 64'd1920);
    op("ror",  5'b01010, 32'd240, 32'd3, 64'd30);
    op("rol",  5'b01011, 32'd240, 32'd3, 64'd1920);

    // Sign-bit shifts and wraps
    op("shra_neg", 5'b01000, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    op("shr_neg",  5'b00111, 32'h8000_0001, 32'd1, 64'h0000_0000_4000_0000);
    op("ror_wrap", 5'b01010, 32'h8000_0001, 32'd1, 64'h0000_0000_C000_0000);
    op("rol_wrap", 5'b01011, 32'h8000_0001, 32'd1, 64'h0000_0000_0000_0003);

    // Only B[4:0] counts; B=32 is a zero count
    op("shl_cnt0", 5'b01001, 32'd240, 32'd32, 64'd240);
    op("ror_cnt0", 5'b01010, 32'h8000_0001, 32'd32, 64'h0000_0000_8000_0001);
    op("shr_cnt33", 5'b00111, 32'd240, 32'd33, 64'd120);

    // Multiply
    op("mul_pos", 5'b01111, 32'd240, 32'd3, 64'd720);
    op("mul_neg", 5'b01111, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    op("mul_big", 5'b01111, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

    // Divide (hi = remainder, lo = quotient) or zero without the divider
`ifdef ALU_DIV_EN
    op("div_pos",  5'b10000, 32'd240, 32'd3, 64'h0000_0000_0000_0050);
    op("div_neg",  5'b10000, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    op("div_zero", 5'b10000, 32'd240, 32'd0, 64'h0000_00F0_FFFF_FFFF);
    op("div_ovf",  5'b10000, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    op("div_rem",  5'b10000, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2);
`else
    op("div_off",  5'b10000, 32'd240, 32'd3, 64'h0);
    op("div_off0", 5'b10000, 32'd240, 32'd0, 64'h0);
`endif

    // Unlisted opcodes
    op("op_00000", 5'b00000, 32'd240, 32'd3, 64'h0);
    op("op_11111", 5'b11111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0);

    // Z follows C_result one clock later
    op("add_reg", 5'b00011, 32'd240, 32'd3, 64'd243);
    check_z("z_add", 64'd243);
    op("mul_reg", 5'b01111, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
    check_z("z_mul", 64'hFFFF_FFFF_FFFF_FFFA);

    // Clear overrides the load for one edge; C_result unaffected
    @(negedge clk);
    clear = 1'b1;
    #1;
    check_eq("c_during_clear", C_result, 64'hFFFF_FFFF_FFFF_FFFA);
    check_z("z_clear", 64'h0);
    @(negedge clk);
    clear = 1'b0;
    check_z("z_reload", 64'hFFFF_FFFF_FFFF_FFFA);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
